// File: rtl/fixed_product_requantizer.sv
// fixed_product_requantizer: accumulates VEC_LEN sign-magnitude Q2.12 products and requantizes the sum to sign-magnitude Q1.6
//   iClk    clock, rising edge
//   iRst    asynchronous active-high reset
//   iValid  product present on iProd
//   oReady  product accepted this cycle (decoded from state only)
//   iProd   sign-magnitude product, [IN_WIDTH-1] is the sign
//   oValid  oResult/oSat hold a completed result
//   iReady  downstream accepts the result
//   oResult sign-magnitude Q1.6 result
//   oSat    result magnitude was clipped
module fixed_product_requantizer #(
  parameter int IN_WIDTH  = 15,
  parameter int OUT_WIDTH = 8,
  parameter int FRAC_IN   = 12,
  parameter int FRAC_OUT  = 6,
  parameter int VEC_LEN   = 8,
  parameter int ACC_WIDTH = 19
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iValid,
  output logic                 oReady,
  input  logic [IN_WIDTH-1:0]  iProd,
  output logic                 oValid,
  input  logic                 iReady,
  output logic [OUT_WIDTH-1:0] oResult,
  output logic                 oSat
);
  localparam int CNT_W  = $clog2(VEC_LEN);
  localparam int SHIFT  = FRAC_IN - FRAC_OUT;
  localparam int MAXMAG = 2 ** (OUT_WIDTH - 1) - 1;
  typedef enum logic [1:0] {S_ACC, S_RND, S_OUT} state_t;
  state_t state, stateNext;
  logic [ACC_WIDTH-1:0] acc, prodMag, prodVal, accAbs;
  logic [ACC_WIDTH:0] rnd;
  logic [CNT_W-1:0] count;
  logic [OUT_WIDTH-2:0] resMag;
  logic beat, lastBeat, sat;
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= S_ACC;
    else state <= stateNext;
  end
  always_comb begin
    oReady    = state == S_ACC;
    beat      = iValid && oReady;
    lastBeat  = count == CNT_W'(VEC_LEN - 1);
    stateNext = state == S_ACC ? (beat && lastBeat ? S_RND : S_ACC)
              : state == S_RND ? S_OUT
              : (iReady ? S_ACC : S_OUT);
  end
  // Negative zero converts to 0, so it never disturbs the sum
  assign prodMag = ACC_WIDTH'(iProd[IN_WIDTH-2:0]);
  assign prodVal = iProd[IN_WIDTH-1] ? -prodMag : prodMag;
  // Rounding on the magnitude gives round-half-away-from-zero for both signs
  assign accAbs = acc[ACC_WIDTH-1] ? -acc : acc;
  assign rnd    = ({1'b0, accAbs} + (ACC_WIDTH+1)'(2 ** (SHIFT - 1))) >> SHIFT;
  assign sat    = rnd > (ACC_WIDTH+1)'(MAXMAG);
  assign resMag = sat ? '1 : rnd[OUT_WIDTH-2:0];
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      acc     <= '0;
      count   <= '0;
      oValid  <= 1'b0;
      oResult <= '0;
      oSat    <= 1'b0;
    end else begin
      if (beat) begin
        acc   <= acc + prodVal;
        count <= lastBeat ? '0 : count + CNT_W'(1);
      end
      if (state == S_RND) begin
        oValid  <= 1'b1;
        oResult <= {acc[ACC_WIDTH-1] && resMag != '0, resMag};
        oSat    <= sat;
      end
      if (state == S_OUT && iReady) begin
        oValid <= 1'b0;
        acc    <= '0;
      end
    end
  end
endmodule

// File: tb/tb_fixed_product_requantizer.sv
// tb_fixed_product_requantizer: directed checks of accumulation, rounding, saturation, handshake and reset
module tb_fixed_product_requantizer;
  logic iClk = 1'b0, iRst = 1'b0, iValid = 1'b0, iReady = 1'b0;
  logic [14:0] iProd = '0;
  logic oReady, oValid, oSat;
  logic [7:0] oResult;
  int checks = 0, errors = 0;
  fixed_product_requantizer dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady), .iProd(iProd),
    .oValid(oValid), .iReady(iReady), .oResult(oResult), .oSat(oSat)
  );
  always #5 iClk = ~iClk;
  task automatic sendVec(input logic [14:0] a, input logic [14:0] b, input int na);
    for (int i = 0; i < 8; i++) begin
      iValid = 1'b1;
      iProd  = i < na ? a : b;
      @(posedge iClk); #1;
    end
    iValid = 1'b0;
  endtask
  task automatic test_reset;
    @(posedge iClk); #2;
    iRst = 1'b1;
    #1;
    checks++;
    if ({oValid, oReady, oResult, oSat} !== {1'b1 ^ 1'b1, 1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset: valid=%b ready=%b result=%h sat=%b, required 0 1 00 0", oValid, oReady, oResult, oSat);
    end
    #3;
    iRst = 1'b0;
    @(posedge iClk); #1;
  endtask
  task automatic test_vectors;
    logic [14:0] ta[9] = '{15'h0200, 15'h0200, 15'h4200, 15'h0020, 15'h4020, 15'h001F, 15'h3FFF, 15'h7FFF, 15'h4000};
    logic [14:0] tb[9] = '{15'h0200, 15'h4200, 15'h4200, 15'h0000, 15'h0000, 15'h0000, 15'h3FFF, 15'h7FFF, 15'h4000};
    int tn[9] = '{8, 4, 8, 1, 1, 1, 8, 8, 8};
    logic [7:0] er[9] = '{8'h40, 8'h00, 8'hC0, 8'h01, 8'h81, 8'h00, 8'h7F, 8'hFF, 8'h00};
    logic es[9] = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
    for (int v = 0; v < 9; v++) begin
      sendVec(ta[v], tb[v], tn[v]);
      checks++;
      if (oValid !== 1'b0 || oReady !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_rnd: valid=%b ready=%b, required 0 0", v, oValid, oReady);
      end
      @(posedge iClk); #1;
      checks++;
      if ({oValid, oResult, oSat} !== {1'b1, er[v], es[v]}) begin
        errors++;
        $display("FAIL vec%0d_result: valid=%b result=%h sat=%b, required 1 %h %b", v, oValid, oResult, oSat, er[v], es[v]);
      end
      iReady = 1'b1;
      @(posedge iClk); #1;
      iReady = 1'b0;
      checks++;
      if ({oValid, oReady, oResult} !== {1'b0, 1'b1, er[v]}) begin
        errors++;
        $display("FAIL vec%0d_drain: valid=%b ready=%b result=%h, required 0 1 %h", v, oValid, oReady, oResult, er[v]);
      end
    end
  endtask
  task automatic test_backpressure;
    sendVec(15'h4200, 15'h4200, 8);
    @(posedge iClk); #1;
    iValid = 1'b1;
    iProd  = 15'h3FFF;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({oValid, oReady, oResult, oSat} !== {1'b1, 1'b0, 8'hC0, 1'b0}) begin
        errors++;
        $display("FAIL hold%0d: valid=%b ready=%b result=%h sat=%b, required 1 0 c0 0", c, oValid, oReady, oResult, oSat);
      end
      @(posedge iClk); #1;
    end
    iValid = 1'b0;
    iReady = 1'b1;
    @(posedge iClk); #1;
    iReady = 1'b0;
    checks++;
    if (oValid !== 1'b0 || oReady !== 1'b1) begin
      errors++;
      $display("FAIL release: valid=%b ready=%b, required 0 1", oValid, oReady);
    end
    sendVec(15'h0200, 15'h0200, 8);
    @(posedge iClk); #1;
    checks++;
    if ({oValid, oResult, oSat} !== {1'b1, 8'h40, 1'b0}) begin
      errors++;
      $display("FAIL after_hold: valid=%b result=%h sat=%b, required 1 40 0", oValid, oResult, oSat);
    end
    iReady = 1'b1;
    @(posedge iClk); #1;
    iReady = 1'b0;
  endtask
  task automatic test_reset_mid_output;
    sendVec(15'h3FFF, 15'h3FFF, 8);
    @(posedge iClk); #2;
    iRst = 1'b1;
    #1;
    checks++;
    if ({oValid, oReady, oResult, oSat} !== {1'b0, 1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_out: valid=%b ready=%b result=%h sat=%b, required 0 1 00 0", oValid, oReady, oResult, oSat);
    end
    #3;
    iRst = 1'b0;
    @(posedge iClk); #1;
  endtask
  task automatic test_reset_recovery;
    for (int i = 0; i < 3; i++) begin
      iValid = 1'b1;
      iProd  = 15'h3FFF;
      @(posedge iClk); #1;
    end
    iValid = 1'b0;
    #2;
    iRst = 1'b1;
    #2;
    iRst = 1'b0;
    @(posedge iClk); #1;
    sendVec(15'h0200, 15'h0200, 8);
    @(posedge iClk); #1;
    checks++;
    if ({oValid, oResult, oSat} !== {1'b1, 8'h40, 1'b0}) begin
      errors++;
      $display("FAIL recovery: valid=%b result=%h sat=%b, required 1 40 0", oValid, oResult, oSat);
    end
    iReady = 1'b1;
    @(posedge iClk); #1;
    iReady = 1'b0;
  endtask
  initial begin
    test_reset;
    test_vectors;
    test_backpressure;
    test_reset_mid_output;
    test_reset_recovery;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
